jtobj_linescan: RTL and testbench
=================================

Name: jtobj_linescan

Overview:
- Parametrised per-line sprite table scanner for Konami-style object chips. It is the next generation of the 053246/053244 scan engine.
- On each active line it walks an object table in external dual-port RAM and tests vertical zone membership with vertical zoom. For each visible object it emits one draw request per 16-px tile column to the line-buffer drawer, over a valid/ready handshake.
- Adds three features over the previous engine: configurable table depth, a per-line tile budget with overflow reporting, and abort-on-late-line.

Parameters:
- OBJW, 8, object index width; table holds 2**OBJW objects.
- VW, 10, position width (y, x, line arithmetic).
- ZW, 10, vertical zoom width; the value 'h40 is 1:1.
- MAXT, 32, tile draw requests allowed per line (1..255).
- LINE_MIN, 9'h010, first active line (inclusive).
- LINE_MAX, 9'h0F0, last active line (exclusive).

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  clock enable; all state advances only when cen=1
- hs  in  1  horizontal sync; its rising edge starts a line
- vdump  in  9  current line number, sampled at the hs edge
- gflip  in  2  global flip {v,h}
- tbl_addr  out  OBJW+3  {obj, word[2:0]} into the object RAM
- tbl_data  in  16  RAM data, valid 1 cen-cycle after the address
- obj_valid  out  1  draw request valid
- obj_ready  in  1  drawer accepts the request
- code  out  16  tile code with row/column bits merged
- attr  out  8  palette/priority attributes
- hpos  out  VW  tile left x
- ysub  out  4  row inside the tile
- hflip  out  1  effective horizontal flip
- vflip  out  1  effective vertical flip
- line_ovf  out  1  one-cen pulse: tile budget exhausted on this line
- line_late  out  1  one-cen pulse: hs arrived before the scan finished
- debug_bus  in  8  object index to suppress (only used with the macro)

Behaviour:
- Reset: all outputs 0. The FSM enters IDLE. obj index = 0, tile count = 0.
- Object table entry layout:
  - word0: [15] enable, [13:12] vsz, [11:10] hsz, [9] vf, [8] hf, [7:0] attr
  - word1: code
  - word2: y[VW-1:0]
  - word3: x[VW-1:0]
  - word4: vzoom[ZW-1:0]
  - words 5-7: unused
- Line start: a rising hs edge (hs & ~hs_l, sampled on cen) with LINE_MIN <= vdump < LINE_MAX causes:
  - vdump is latched.
  - obj index and tile count are cleared.
  - the FSM goes to RD0.
  - if the FSM was not in IDLE at that edge, line_late pulses and the old scan is abandoned. obj_valid drops in the same cycle.
- States:
  - IDLE: no activity.
  - RD0..RD4: one word per cen cycle; the address leads the data by 1.
  - RD0 data has enable=0 → NEXT immediately; no further words are read.
  - CALC: one cycle. Computes:
    - diff = line − y (VW bits, signed)
    - ydiff = (diff·vzoom) >> 6
    - inzone = diff ≥ 0 and ydiff < 16<<vsz
    - vf_eff = vf ^ gflip[1]
    - row = ydiff[6:4] masked to vsz bits, inverted when vf_eff
    - code[5,3,1] += row
    - ysub = ydiff[3:0] ^ {4{vf_eff}}
    - with gflip[0]=1, x = −x.
  - CALC → EMIT if inzone, else → NEXT.
  - EMIT:
    - Drives obj_valid with hpos = x + 16·step.
    - Column = step ^ ({3{hf_eff}} masked to hsz bits), placed in code[4,2,0]. hf_eff = hf ^ gflip[0].
    - On a cycle where obj_valid & obj_ready & cen: step++ and tile count++.
    - If the tile count reaches MAXT: line_ovf pulses and the FSM goes to IDLE. The remaining objects are skipped.
    - After step reaches (1<<hsz)−1 and is accepted → NEXT.
    - While obj_ready is low, all outputs are held stable.
  - NEXT: obj index++. On wrap back to 0 → IDLE, otherwise → RD0.
- Arithmetic: diff·vzoom is a full-width product (VW+ZW bits) and is truncated after the shift. The 3-bit code adds wrap modulo 8 inside their bit slots.
- hpos wraps modulo 2**VW. A tile with hpos in the upper half is still emitted; clipping belongs to the drawer.
- obj_valid never asserts outside EMIT.

Optional Feature:
- Macro: JTOBJ_DEBUG_SKIP_EN.
- Defined: in RD0, an object whose index[OBJW-1:0] equals debug_bus[OBJW-1:0] is treated as disabled.
- Undefined: debug_bus is ignored; this is the normal release build.

Test Plan:
- Object 0 with enable=1, y=20, x=100, vsz=0, hsz=1, vzoom='h40, code='h1000; line 25; obj_ready tied 1 → exactly two requests: hpos 100/116, ysub 5, codes 'h1000/'h1001. Then scan completes to IDLE, no pulses.
- Same object, vzoom='h80, line 27 → ydiff=14, ysub 14. Line 29 → ydiff=18 ≥ 16, out of zone, no request.
- 64 enabled objects each with hsz=3 on one line, MAXT=32 → exactly 32 accepted requests, then one line_ovf pulse; objects 4+ are not read.
- obj_ready held low for 10 cycles during EMIT → code, hpos and ysub stay constant; request count is unchanged.
- hs edge while in EMIT → line_late pulse, obj_valid low in the same cycle, new scan restarts at object 0 with the new line.
- With JTOBJ_DEBUG_SKIP_EN and debug_bus=0, object 0 is enabled and in zone → no requests. Without the macro → requests are issued.

Source files
------------

// File: rtl/jtobj_linescan.sv
// rtl/jtobj_linescan.sv - per-line object table scanner emitting tile draw requests
// Build macro JTOBJ_DEBUG_SKIP_EN: treat the object at index debug_bus as disabled.

module jtobj_linescan #(
    parameter int         OBJW     = 8,
    parameter int         VW       = 10,
    parameter int         ZW       = 10,
    parameter int         MAXT     = 32,
    parameter logic [8:0] LINE_MIN = 9'h010,
    parameter logic [8:0] LINE_MAX = 9'h0F0
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            cen,
    input  logic            hs,
    input  logic [8:0]      vdump,
    input  logic [1:0]      gflip,
    output logic [OBJW+2:0] tbl_addr,
    input  logic [15:0]     tbl_data,
    output logic            obj_valid,
    input  logic            obj_ready,
    output logic [15:0]     code,
    output logic [7:0]      attr,
    output logic [VW-1:0]   hpos,
    output logic [3:0]      ysub,
    output logic            hflip,
    output logic            vflip,
    output logic            line_ovf,
    output logic            line_late,
    input  logic [7:0]      debug_bus
);

    localparam int PW = VW + ZW;

    typedef enum logic [3:0] {
        IDLE, RD0, RD1, RD2, RD3, RD4, CALC, EMIT, NEXT
    } state_t;

    state_t          st, st_nxt;
    logic            hs_l;
    logic [8:0]      line_r;
    logic [OBJW-1:0] obj_idx, obj_nxt;
    logic [7:0]      tile_cnt;
    logic [2:0]      step;
    logic [1:0]      vsz_r, hsz_r;
    logic            vf_r, hf_r, vf_eff_r, hf_eff_r;
    logic [7:0]      attr_r;
    logic [15:0]     code_r;
    logic [VW-1:0]   y_r, x_r;
    logic [ZW-1:0]   vzoom_r;
    logic [3:0]      ysub_r;
    logic            ovf_r, late_r;

    logic            line_start, accept, skip, inzone, last_col;
    logic            ovf_hit, late_hit;
    logic [2:0]      rd_word;
    logic [VW-1:0]   diff, x_calc;
    logic [PW-1:0]   prod, ydiff, zone_lim;
    logic [2:0]      vmask, hmask, row, col, odd_sum, even_sum;
    logic            vf_eff;
    logic [15:0]     code_calc;
    logic [3:0]      ysub_calc;

    assign line_start = cen && hs && !hs_l && (vdump >= LINE_MIN) && (vdump < LINE_MAX);
    assign obj_valid  = (st == EMIT) && !line_start;
    assign accept     = obj_valid && obj_ready && cen;

`ifdef JTOBJ_DEBUG_SKIP_EN
    assign skip = !tbl_data[15] || (obj_idx == debug_bus[OBJW-1:0]);
    logic unused_bits;
    assign unused_bits = tbl_data[14];
`else
    assign skip = !tbl_data[15];
    logic unused_bits;
    assign unused_bits = ^{tbl_data[14], debug_bus};
`endif

    // Vertical zone test with zoom; the product is two's complement, so a
    // negative diff is rejected by its sign bit rather than by the compare.
    always_comb begin
        diff      = VW'(line_r) - y_r;
        prod      = {{ZW{diff[VW-1]}}, diff} * {{VW{1'b0}}, vzoom_r};
        ydiff     = prod >> 6;
        zone_lim  = PW'(16) << vsz_r;
        inzone    = !diff[VW-1] && (ydiff < zone_lim);
        vmask     = (3'd1 << vsz_r) - 3'd1;
        vf_eff    = vf_r ^ gflip[1];
        row       = (ydiff[6:4] ^ {3{vf_eff}}) & vmask;
        odd_sum   = {code_r[5], code_r[3], code_r[1]} + row;
        code_calc = code_r;
        code_calc[5] = odd_sum[2];
        code_calc[3] = odd_sum[1];
        code_calc[1] = odd_sum[0];
        ysub_calc = ydiff[3:0] ^ {4{vf_eff}};
        x_calc    = gflip[0] ? (VW'(0) - x_r) : x_r;
    end

    // Column bits are merged into the even code slots from the live step
    // counter, so everything stays frozen while the drawer stalls.
    always_comb begin
        hmask    = (3'd1 << hsz_r) - 3'd1;
        col      = step ^ ({3{hf_eff_r}} & hmask);
        even_sum = {code_r[4], code_r[2], code_r[0]} + col;
        last_col = (step == hmask);
        code     = code_r;
        code[4]  = even_sum[2];
        code[2]  = even_sum[1];
        code[0]  = even_sum[0];
        hpos     = x_r + VW'({step, 4'b0000});
    end

    assign attr      = attr_r;
    assign ysub      = ysub_r;
    assign hflip     = hf_eff_r;
    assign vflip     = vf_eff_r;
    assign line_ovf  = ovf_r;
    assign line_late = late_r;

    always_comb begin
        st_nxt   = st;
        obj_nxt  = obj_idx;
        ovf_hit  = 1'b0;
        late_hit = 1'b0;
        if (line_start) begin
            st_nxt   = RD0;
            obj_nxt  = '0;
            late_hit = (st != IDLE);
        end else if (cen) begin
            case (st)
                RD0:  st_nxt = skip ? NEXT : RD1;
                RD1:  st_nxt = RD2;
                RD2:  st_nxt = RD3;
                RD3:  st_nxt = RD4;
                RD4:  st_nxt = CALC;
                CALC: st_nxt = inzone ? EMIT : NEXT;
                EMIT: begin
                    if (accept) begin
                        if (tile_cnt + 8'd1 == 8'(MAXT)) begin
                            ovf_hit = 1'b1;
                            st_nxt  = IDLE;
                        end else if (last_col) begin
                            st_nxt = NEXT;
                        end
                    end
                end
                NEXT: begin
                    obj_nxt = obj_idx + OBJW'(1);
                    st_nxt  = (obj_nxt == '0) ? IDLE : RD0;
                end
                default: st_nxt = IDLE;
            endcase
        end
    end

    // The RAM answers one cen cycle late, so the address follows the
    // state being entered rather than the current one.
    always_comb begin
        case (st_nxt)
            RD1:     rd_word = 3'd1;
            RD2:     rd_word = 3'd2;
            RD3:     rd_word = 3'd3;
            RD4:     rd_word = 3'd4;
            default: rd_word = 3'd0;
        endcase
        tbl_addr = {obj_nxt, rd_word};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            hs_l     <= 1'b0;
            line_r   <= '0;
            obj_idx  <= '0;
            tile_cnt <= '0;
            step     <= '0;
            vsz_r    <= '0;
            hsz_r    <= '0;
            vf_r     <= 1'b0;
            hf_r     <= 1'b0;
            vf_eff_r <= 1'b0;
            hf_eff_r <= 1'b0;
            attr_r   <= '0;
            code_r   <= '0;
            y_r      <= '0;
            x_r      <= '0;
            vzoom_r  <= '0;
            ysub_r   <= '0;
            ovf_r    <= 1'b0;
            late_r   <= 1'b0;
        end else if (cen) begin
            hs_l    <= hs;
            st      <= st_nxt;
            obj_idx <= obj_nxt;
            ovf_r   <= ovf_hit;
            late_r  <= late_hit;
            if (line_start) begin
                line_r   <= vdump;
                tile_cnt <= '0;
            end else begin
                case (st)
                    RD0: {vsz_r, hsz_r, vf_r, hf_r, attr_r} <= tbl_data[13:0];
                    RD1: code_r  <= tbl_data;
                    RD2: y_r     <= tbl_data[VW-1:0];
                    RD3: x_r     <= tbl_data[VW-1:0];
                    RD4: vzoom_r <= tbl_data[ZW-1:0];
                    CALC: begin
                        code_r   <= code_calc;
                        ysub_r   <= ysub_calc;
                        x_r      <= x_calc;
                        vf_eff_r <= vf_eff;
                        hf_eff_r <= hf_r ^ gflip[0];
                        step     <= '0;
                    end
                    EMIT: begin
                        if (accept) begin
                            tile_cnt <= tile_cnt + 8'd1;
                            step     <= step + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jtobj_linescan.sv
// tb/tb_jtobj_linescan.sv - randomized scoreboard bench for jtobj_linescan
module tb_jtobj_linescan;

    localparam int OBJW = 8;
    localparam int VW   = 10;
    localparam int ZW   = 10;
    localparam int MAXT = 32;

    logic            rst, clk, cen, hs;
    logic [8:0]      vdump;
    logic [1:0]      gflip;
    logic [OBJW+2:0] tbl_addr;
    logic [15:0]     tbl_data = '0;
    logic            obj_valid, obj_ready;
    logic [15:0]     code;
    logic [7:0]      attr;
    logic [VW-1:0]   hpos;
    logic [3:0]      ysub;
    logic            hflip, vflip, line_ovf, line_late;
    logic [7:0]      debug_bus;

    jtobj_linescan #(.OBJW(OBJW), .VW(VW), .ZW(ZW), .MAXT(MAXT)) dut (
        .rst(rst), .clk(clk), .cen(cen), .hs(hs), .vdump(vdump), .gflip(gflip),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .obj_valid(obj_valid),
        .obj_ready(obj_ready), .code(code), .attr(attr), .hpos(hpos), .ysub(ysub),
        .hflip(hflip), .vflip(vflip), .line_ovf(line_ovf), .line_late(line_late),
        .debug_bus(debug_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:2047];
    always @(posedge clk) if (cen) tbl_data <= mem[tbl_addr];

    int checks = 0, errors = 0;
    int ovf_seen = 0, late_seen = 0, accepted = 0;
    int base_ovf, base_late, base_acc, exp_ovf;
    int max_obj = 0;
    bit track = 0, rnd = 0;
    logic [39:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (cen && line_ovf)  ovf_seen++;
            if (cen && line_late) late_seen++;
            if (track && int'(tbl_addr[OBJW+2:3]) > max_obj) max_obj = int'(tbl_addr[OBJW+2:3]);
            if (obj_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_req", 64'(obj_valid), 64'(0));
                end else begin
                    check("req", 64'({code, attr, hpos, ysub, hflip, vflip}), 64'(exp_q[0]));
                    if (obj_ready && cen) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic put_obj(input int o, input int vsz, input int hsz, input bit vf, input bit hf,
                           input int at, input int cd, input int y, input int x, input int vz);
        mem[o*8+0] = {1'b1, 1'b0, 2'(vsz), 2'(hsz), vf, hf, 8'(at)};
        mem[o*8+1] = 16'(cd);
        mem[o*8+2] = 16'(y & 1023);
        mem[o*8+3] = 16'(x & 1023);
        mem[o*8+4] = 16'(vz & 1023);
    endtask

    // Reference: walk the table in index order, apply the zone/zoom/flip
    // rules with integer arithmetic and cut the request list at MAXT tiles.
    task automatic model_line(input int line, input logic [1:0] gf, output int n_ovf);
        int cnt, y, x, vz, vsz, hsz, d, yd, r, row, nrows, ncols, col, xe, ys;
        bit vfe, hfe;
        logic [15:0] w0, cd, c2;
        logic [2:0] s3;
        cnt = 0;
        n_ovf = 0;
        for (int o = 0; o < 256; o++) begin
            if (n_ovf != 0) break;
            w0 = mem[o*8];
            if (!w0[15]) continue;
`ifdef JTOBJ_DEBUG_SKIP_EN
            if (o == int'(debug_bus)) continue;
`endif
            vsz = int'(w0[13:12]);
            hsz = int'(w0[11:10]);
            y   = int'(mem[o*8+2]) & 1023;
            x   = int'(mem[o*8+3]) & 1023;
            vz  = int'(mem[o*8+4]) & 1023;
            d   = (line - y) & 1023;
            if (d >= 512) continue;
            yd    = (d * vz) >> 6;
            nrows = 1 << vsz;
            if (yd >= 16 * nrows) continue;
            vfe = w0[9] ^ gf[1];
            hfe = w0[8] ^ gf[0];
            r   = yd / 16;
            row = vfe ? nrows - 1 - r : r;
            cd  = mem[o*8+1];
            s3  = {cd[5], cd[3], cd[1]} + 3'(row);
            cd[5] = s3[2]; cd[3] = s3[1]; cd[1] = s3[0];
            ys  = vfe ? 15 - (yd % 16) : yd % 16;
            xe  = gf[0] ? (1024 - x) & 1023 : x;
            ncols = 1 << hsz;
            for (int s = 0; s < ncols; s++) begin
                col = hfe ? ncols - 1 - s : s;
                c2  = cd;
                s3  = {cd[4], cd[2], cd[0]} + 3'(col);
                c2[4] = s3[2]; c2[2] = s3[1]; c2[0] = s3[0];
                exp_q.push_back({c2, w0[7:0], 10'((xe + 16*s) & 1023), 4'(ys), hfe, vfe});
                cnt++;
                if (cnt == MAXT) begin
                    n_ovf = 1;
                    break;
                end
            end
        end
    endtask

    task automatic pulse_hs(input int line);
        vdump = 9'(line);
        cen = 1'b1;
        hs = 1'b1;
        @(posedge clk); #1;
        hs = 1'b0;
    endtask

    task automatic begin_line(input int line, input logic [1:0] gf);
        base_ovf  = ovf_seen;
        base_late = late_seen;
        base_acc  = accepted;
        exp_ovf   = 0;
        gflip     = gf;
        if (line >= 'h10 && line < 'hF0) model_line(line, gf, exp_ovf);
        pulse_hs(line);
    endtask

    task automatic finish_line(input string tag, input int exp_late);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 20000) begin
            if (rnd) begin
                cen       = ($urandom_range(0, 4) != 0);
                obj_ready = ($urandom_range(0, 3) != 0);
            end else begin
                cen       = 1'b1;
                obj_ready = 1'b1;
            end
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        cen = 1'b1;
        obj_ready = 1'b1;
        repeat (2500) @(posedge clk);
        #1;
        check({tag, "_ovf"}, 64'(ovf_seen - base_ovf), 64'(exp_ovf));
        check({tag, "_late"}, 64'(late_seen - base_late), 64'(exp_late));
    endtask

    task automatic wait_valid(input string tag);
        int guard;
        guard = 0;
        while (!obj_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        check({tag, "_first_req"}, 64'(obj_valid), 64'(1));
    endtask

    initial begin
        rst = 1'b1; cen = 1'b1; hs = 1'b0; vdump = '0; gflip = '0;
        obj_ready = 1'b1; debug_bus = '0;
        clear_mem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 64'({tbl_addr, obj_valid, code, attr, hpos, ysub, hflip,
                                  vflip, line_ovf, line_late}), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // basic 1:1 object, two columns
        put_obj(0, 0, 1, 0, 0, 'h00, 'h1000, 20, 100, 'h40);
        begin_line(25, 2'b00);
        finish_line("basic", 0);
        check("basic_count", 64'(accepted - base_acc), 64'(2));

        // 2x vertical zoom: inside then just outside the zone
        put_obj(0, 0, 1, 0, 0, 'h00, 'h1000, 20, 100, 'h80);
        begin_line(27, 2'b00);
        finish_line("zoom_in", 0);
        begin_line(29, 2'b00);
        finish_line("zoom_out", 0);
        check("zoom_out_count", 64'(accepted - base_acc), 64'(0));

        // tile budget exhaustion
        clear_mem();
        for (int i = 0; i < 64; i++) put_obj(i, 0, 3, 0, 0, i, 'h0100 * i, 20, 16 * i, 'h40);
        max_obj = 0;
        track = 1'b1;
        begin_line(25, 2'b00);
        finish_line("budget", 0);
        track = 1'b0;
        check("budget_count", 64'(accepted - base_acc), 64'(MAXT));
        check("budget_last_obj", 64'(max_obj), 64'(3));

        // drawer stall holds the request
        clear_mem();
        put_obj(0, 1, 3, 1, 0, 'h5A, 'h2345, 20, 1000, 'h40);
        obj_ready = 1'b0;
        begin_line(25, 2'b00);
        wait_valid("stall");
        repeat (10) @(posedge clk);
        #1;
        check("stall_count", 64'(accepted - base_acc), 64'(0));
        finish_line("stall", 0);

        // late hs during EMIT
        clear_mem();
        put_obj(0, 0, 3, 0, 1, 'h11, 'h0800, 20, 50, 'h40);
        obj_ready = 1'b0;
        begin_line(25, 2'b01);
        wait_valid("late");
        repeat (3) @(posedge clk);
        #1;
        check("late_pre_count", 64'(accepted - base_acc), 64'(0));
        exp_q.delete();
        model_line(26, 2'b01, exp_ovf);
        vdump = 9'd26; cen = 1'b1; hs = 1'b1;
        @(negedge clk);
        check("late_valid_drop", 64'(obj_valid), 64'(0));
        @(posedge clk); #1;
        hs = 1'b0;
        @(negedge clk);
        check("late_pulse", 64'({line_late, obj_valid}), 64'(2'b10));
        @(posedge clk); #1;
        finish_line("late", 1);

        // debug index 0 on an enabled, visible object
        clear_mem();
        put_obj(0, 0, 1, 0, 0, 'h00, 'h1000, 20, 100, 'h40);
        debug_bus = 8'h00;
        begin_line(25, 2'b00);
        finish_line("debug", 0);

        // active-line window boundaries
        put_obj(1, 0, 0, 0, 0, 'h22, 'h0040, 0, 8, 'h40);
        put_obj(2, 0, 0, 0, 0, 'h33, 'h0080, 230, 16, 'h40);
        begin_line(15, 2'b00);
        finish_line("line_below", 0);
        check("line_below_count", 64'(accepted - base_acc), 64'(0));
        begin_line(16, 2'b00);
        finish_line("line_min", 0);
        begin_line(239, 2'b00);
        finish_line("line_max_m1", 0);
        begin_line(240, 2'b00);
        finish_line("line_max", 0);
        check("line_max_count", 64'(accepted - base_acc), 64'(0));

        // randomized tables, flips, cen and ready
        rnd = 1'b1;
        for (int n = 0; n < 6; n++) begin
            int ln, vz;
            logic [1:0] gf;
            ln = $urandom_range(16, 239);
            gf = 2'($urandom_range(0, 3));
            debug_bus = 8'($urandom_range(0, 255));
            clear_mem();
            for (int o = 0; o < 256; o++) begin
                if ($urandom_range(0, 9) == 0) begin
                    case ($urandom_range(0, 3))
                        0: vz = 'h40;
                        1: vz = 'h80;
                        2: vz = 'h20;
                        default: vz = $urandom_range(1, 1023);
                    endcase
                    put_obj(o, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), $urandom_range(0, 255), $urandom_range(0, 65535),
                            ln + 8 - $urandom_range(0, 60), $urandom_range(0, 1023), vz);
                end else begin
                    mem[o*8] = 16'($urandom) & 16'h7FFF;
                end
            end
            begin_line(ln, gf);
            finish_line("random", 0);
        end
        rnd = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
